// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand selection.
// Define ID_EX_FORWARD_EN to build in EX/MEM and MEM/WB forwarding; without it the stage stalls on RAW hazards.
package id_ex_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;
endpackage

module id_ex_stage
   import id_ex_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        id_valid_i,
   input  logic [31:0] id_pc_i,
   input  logic [31:0] id_imm_i,
   input  logic [31:0] id_rs1_data_i,
   input  logic [31:0] id_rs2_data_i,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic [4:0]  id_rd_addr_i,
   input  alu_op_t     id_alu_op_i,
   input  logic        id_src1_pc_i,
   input  logic        id_src2_imm_i,
   input  logic        id_reg_write_i,
   input  logic        id_mem_read_i,
   input  logic        id_mem_write_i,
   input  logic        flush_i,
   input  logic [4:0]  exmem_rd_addr_i,
   input  logic        exmem_reg_write_i,
   input  logic        exmem_mem_read_i,
   input  logic [31:0] exmem_result_i,
   input  logic [4:0]  memwb_rd_addr_i,
   input  logic        memwb_reg_write_i,
   input  logic [31:0] memwb_result_i,
   output logic        stall_o,
   output logic        ex_valid_o,
   output logic        ex_reg_write_o,
   output logic        ex_mem_read_o,
   output logic        ex_mem_write_o,
   output logic [4:0]  ex_rd_addr_o,
   output logic [31:0] ex_pc_o,
   output alu_op_t     ex_alu_op_o,
   output logic [31:0] ex_data1_o,
   output logic [31:0] ex_data2_o,
   output logic [31:0] ex_store_data_o
);

   logic        valid_q, reg_write_q, mem_read_q, mem_write_q;
   logic        src1_pc_q, src2_imm_q;
   logic [4:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
   logic [31:0] pc_q, imm_q, rs1_data_q, rs2_data_q;
   alu_op_t     alu_op_q;

   logic        load_use, raw_stall, hazard, load_bubble;
   logic [31:0] rs1_fwd, rs2_fwd;

   // rd != 0 keeps x0 from ever stalling the pipe
   assign load_use = valid_q & mem_read_q & (rd_addr_q != 5'd0) & id_valid_i &
                     ((rd_addr_q == id_rs1_addr_i) | (rd_addr_q == id_rs2_addr_i));

`ifdef ID_EX_FORWARD_EN
   assign raw_stall = 1'b0;

   always_comb begin
      rs1_fwd = rs1_data_q;
      if (exmem_reg_write_i && !exmem_mem_read_i && (exmem_rd_addr_i != 5'd0) &&
          (exmem_rd_addr_i == rs1_addr_q))
         rs1_fwd = exmem_result_i;
      else if (memwb_reg_write_i && (memwb_rd_addr_i != 5'd0) && (memwb_rd_addr_i == rs1_addr_q))
         rs1_fwd = memwb_result_i;

      rs2_fwd = rs2_data_q;
      if (exmem_reg_write_i && !exmem_mem_read_i && (exmem_rd_addr_i != 5'd0) &&
          (exmem_rd_addr_i == rs2_addr_q))
         rs2_fwd = exmem_result_i;
      else if (memwb_reg_write_i && (memwb_rd_addr_i != 5'd0) && (memwb_rd_addr_i == rs2_addr_q))
         rs2_fwd = memwb_result_i;
   end
`else
   logic raw_rs1, raw_rs2;
   logic unused_fwd;

   // regfile writes before it reads, so only EX and EX/MEM producers need a wait
   assign raw_rs1 = (id_rs1_addr_i != 5'd0) &
                    ((reg_write_q & (rd_addr_q == id_rs1_addr_i)) |
                     (exmem_reg_write_i & (exmem_rd_addr_i == id_rs1_addr_i)));
   assign raw_rs2 = (id_rs2_addr_i != 5'd0) &
                    ((reg_write_q & (rd_addr_q == id_rs2_addr_i)) |
                     (exmem_reg_write_i & (exmem_rd_addr_i == id_rs2_addr_i)));
   assign raw_stall = id_valid_i & (raw_rs1 | raw_rs2);

   assign rs1_fwd = rs1_data_q;
   assign rs2_fwd = rs2_data_q;

   assign unused_fwd = ^{exmem_mem_read_i, exmem_result_i, memwb_rd_addr_i,
                         memwb_reg_write_i, memwb_result_i, rs1_addr_q, rs2_addr_q};
`endif

   assign hazard      = load_use | raw_stall;
   assign load_bubble = flush_i | hazard | ~id_valid_i;
   assign stall_o     = hazard & ~flush_i & ~rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i || load_bubble) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         src1_pc_q   <= 1'b0;
         src2_imm_q  <= 1'b0;
         rs1_addr_q  <= 5'd0;
         rs2_addr_q  <= 5'd0;
         rd_addr_q   <= 5'd0;
         pc_q        <= 32'd0;
         imm_q       <= 32'd0;
         rs1_data_q  <= 32'd0;
         rs2_data_q  <= 32'd0;
         alu_op_q    <= ALU_ADD;
      end else begin
         valid_q     <= 1'b1;
         reg_write_q <= id_reg_write_i;
         mem_read_q  <= id_mem_read_i;
         mem_write_q <= id_mem_write_i;
         src1_pc_q   <= id_src1_pc_i;
         src2_imm_q  <= id_src2_imm_i;
         rs1_addr_q  <= id_rs1_addr_i;
         rs2_addr_q  <= id_rs2_addr_i;
         rd_addr_q   <= id_rd_addr_i;
         pc_q        <= id_pc_i;
         imm_q       <= id_imm_i;
         rs1_data_q  <= id_rs1_data_i;
         rs2_data_q  <= id_rs2_data_i;
         alu_op_q    <= id_alu_op_i;
      end
   end

   assign ex_valid_o      = valid_q;
   assign ex_reg_write_o  = reg_write_q;
   assign ex_mem_read_o   = mem_read_q;
   assign ex_mem_write_o  = mem_write_q;
   assign ex_rd_addr_o    = rd_addr_q;
   assign ex_pc_o         = pc_q;
   assign ex_alu_op_o     = alu_op_q;
   assign ex_data1_o      = src1_pc_q  ? pc_q  : rs1_fwd;
   assign ex_data2_o      = src2_imm_q ? imm_q : rs2_fwd;
   assign ex_store_data_o = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/forwarding scenarios plus random traffic against a reference model.
// Expectations follow the ID_EX_FORWARD_EN setting the bench is compiled with.
module tb_id_ex_stage;
   import id_ex_pkg::*;

   logic        clk_sys = 1'b0;
   logic        rst_i, id_valid_i, flush_i;
   logic [31:0] id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i;
   logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
   alu_op_t     id_alu_op_i;
   logic        id_src1_pc_i, id_src2_imm_i, id_reg_write_i, id_mem_read_i, id_mem_write_i;
   logic [4:0]  exmem_rd_addr_i, memwb_rd_addr_i;
   logic        exmem_reg_write_i, exmem_mem_read_i, memwb_reg_write_i;
   logic [31:0] exmem_result_i, memwb_result_i;
   logic        stall_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;
   logic [4:0]  ex_rd_addr_o;
   logic [31:0] ex_pc_o, ex_data1_o, ex_data2_o, ex_store_data_o;
   alu_op_t     ex_alu_op_o;

   id_ex_stage dut (
      .clk_i(clk_sys), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
      .id_alu_op_i(id_alu_op_i), .id_src1_pc_i(id_src1_pc_i), .id_src2_imm_i(id_src2_imm_i),
      .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
      .flush_i(flush_i),
      .exmem_rd_addr_i(exmem_rd_addr_i), .exmem_reg_write_i(exmem_reg_write_i),
      .exmem_mem_read_i(exmem_mem_read_i), .exmem_result_i(exmem_result_i),
      .memwb_rd_addr_i(memwb_rd_addr_i), .memwb_reg_write_i(memwb_reg_write_i),
      .memwb_result_i(memwb_result_i),
      .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_reg_write_o(ex_reg_write_o),
      .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .ex_rd_addr_o(ex_rd_addr_o),
      .ex_pc_o(ex_pc_o), .ex_alu_op_o(ex_alu_op_o), .ex_data1_o(ex_data1_o),
      .ex_data2_o(ex_data2_o), .ex_store_data_o(ex_store_data_o)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic        v, s1pc, s2imm, rw, mr, mw;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc, imm, d1, d2;
      alu_op_t     op;
   } instr_t;

   instr_t m;
   int     n_cmp = 0;
   int     n_bad = 0;
   logic   held  = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic instr_t bubble();
      instr_t b;
      b.v = 0; b.s1pc = 0; b.s2imm = 0; b.rw = 0; b.mr = 0; b.mw = 0;
      b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.pc = 0; b.imm = 0; b.d1 = 0; b.d2 = 0;
      b.op = ALU_ADD;
      return b;
   endfunction

   // ID instruction must wait while any source register is still being produced upstream
   function automatic logic exp_hazard();
      logic [4:0] srcs[2];
      logic       h;
      h = 1'b0;
      srcs[0] = id_rs1_addr_i;
      srcs[1] = id_rs2_addr_i;
      if (!id_valid_i) return 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (srcs[k] != 5'd0) begin
            if (m.v && m.mr && m.rd == srcs[k]) h = 1'b1;
`ifndef ID_EX_FORWARD_EN
            if (m.rw && m.rd == srcs[k]) h = 1'b1;
            if (exmem_reg_write_i && exmem_rd_addr_i == srcs[k]) h = 1'b1;
`endif
         end
      end
      return h;
   endfunction

   function automatic logic exp_stall();
      return !rst_i && !flush_i && exp_hazard();
   endfunction

   // newest producer first; a load still in EX/MEM has no value to give yet
   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
`ifdef ID_EX_FORWARD_EN
      logic [4:0]  src_rd[2];
      logic        src_en[2];
      logic [31:0] src_val[2];
      src_rd[0] = exmem_rd_addr_i; src_en[0] = exmem_reg_write_i && !exmem_mem_read_i; src_val[0] = exmem_result_i;
      src_rd[1] = memwb_rd_addr_i; src_en[1] = memwb_reg_write_i;                       src_val[1] = memwb_result_i;
      for (int k = 0; k < 2; k++)
         if (src_en[k] && rs != 5'd0 && src_rd[k] == rs) return src_val[k];
`endif
      return rf;
   endfunction

   task automatic settle();
      #3;
      check_eq("stall", {31'd0, stall_o}, {31'd0, exp_stall()});
      check_eq("valid", {31'd0, ex_valid_o}, {31'd0, m.v});
      check_eq("ctrl", {29'd0, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o}, {29'd0, m.rw, m.mr, m.mw});
      check_eq("rd", {27'd0, ex_rd_addr_o}, {27'd0, m.rd});
      check_eq("pc", ex_pc_o, m.pc);
      check_eq("alu_op", {28'd0, ex_alu_op_o}, {28'd0, m.op});
      check_eq("data1", ex_data1_o, m.s1pc ? m.pc : operand(m.rs1, m.d1));
      check_eq("data2", ex_data2_o, m.s2imm ? m.imm : operand(m.rs2, m.d2));
      check_eq("store", ex_store_data_o, operand(m.rs2, m.d2));
   endtask

   task automatic advance();
      held = exp_stall();
      if (rst_i || flush_i || exp_hazard() || !id_valid_i) m = bubble();
      else begin
         m.v = 1'b1; m.s1pc = id_src1_pc_i; m.s2imm = id_src2_imm_i;
         m.rw = id_reg_write_i; m.mr = id_mem_read_i; m.mw = id_mem_write_i;
         m.rs1 = id_rs1_addr_i; m.rs2 = id_rs2_addr_i; m.rd = id_rd_addr_i;
         m.pc = id_pc_i; m.imm = id_imm_i; m.d1 = id_rs1_data_i; m.d2 = id_rs2_data_i;
         m.op = id_alu_op_i;
      end
      @(posedge clk_sys);
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic rw, input logic mr);
      id_valid_i = v; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
      id_rs1_data_i = d1; id_rs2_data_i = d2; id_reg_write_i = rw; id_mem_read_i = mr;
      id_mem_write_i = 1'b0; id_src1_pc_i = 1'b0; id_src2_imm_i = 1'b0;
      id_pc_i = 32'h40; id_imm_i = 32'h4; id_alu_op_i = ALU_ADD;
   endtask

   task automatic set_fwd(input logic [4:0] erd, input logic erw, input logic emr, input logic [31:0] eres,
                          input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
      exmem_rd_addr_i = erd; exmem_reg_write_i = erw; exmem_mem_read_i = emr; exmem_result_i = eres;
      memwb_rd_addr_i = wrd; memwb_reg_write_i = wrw; memwb_result_i = wres;
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      set_fwd(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
      m = bubble();
      @(posedge clk_sys);
      #1;

      // reset state
      settle();
      check_eq("rst_valid", {31'd0, ex_valid_o}, 32'd0);
      check_eq("rst_alu", {28'd0, ex_alu_op_o}, {28'd0, ALU_ADD});
      check_eq("rst_data1", ex_data1_o, 32'd0);
      check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
      advance();
      rst_i = 1'b0;

      // EX/MEM result beats MEM/WB for the same register
      set_id(1'b1, 5'd5, 5'd6, 5'd9, 32'h11, 32'h22, 1'b1, 1'b0);
      step();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      set_fwd(5'd5, 1'b1, 1'b0, 32'h0000_00AA, 5'd5, 1'b1, 32'h55);
      settle();
`ifdef ID_EX_FORWARD_EN
      check_eq("fwd_exmem", ex_data1_o, 32'hAA);
`else
      check_eq("fwd_exmem", ex_data1_o, 32'h11);
`endif
      advance();
      set_fwd(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
      step();

      // load-use: lw x7 in EX, add x8,x7,x1 in ID
      set_id(1'b1, 5'd2, 5'd0, 5'd7, 32'd0, 32'd0, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd7, 5'd1, 5'd8, 32'h1234, 32'h5, 1'b1, 1'b0);
      settle();
      check_eq("lu_stall", {31'd0, stall_o}, 32'd1);
      advance();
      set_fwd(5'd7, 1'b1, 1'b1, 32'hDEAD, 5'd0, 1'b0, 32'd0);
      settle();
      check_eq("lu_bubble", {31'd0, ex_valid_o}, 32'd0);
      advance();
`ifndef ID_EX_FORWARD_EN
      set_fwd(5'd0, 1'b0, 1'b0, 32'd0, 5'd7, 1'b1, 32'h77);
      step();
`endif
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      set_fwd(5'd0, 1'b0, 1'b0, 32'd0, 5'd7, 1'b1, 32'h77);
      settle();
      check_eq("lu_issue_rd", {27'd0, ex_rd_addr_o}, 32'd8);
`ifdef ID_EX_FORWARD_EN
      check_eq("lu_fwd", ex_data1_o, 32'h77);
`else
      check_eq("lu_fwd", ex_data1_o, 32'h1234);
`endif
      advance();
      set_fwd(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
      step();

      // flush wins over a simultaneous load-use hazard
      set_id(1'b1, 5'd2, 5'd0, 5'd7, 32'd0, 32'd0, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd7, 5'd1, 5'd8, 32'h1234, 32'h5, 1'b1, 1'b0);
      flush_i = 1'b1;
      settle();
      check_eq("flush_stall", {31'd0, stall_o}, 32'd0);
      advance();
      flush_i = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      settle();
      check_eq("flush_bubble", {31'd0, ex_valid_o}, 32'd0);
      advance();

      // x0 is never forwarded
      set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 1'b1, 1'b0);
      step();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      set_fwd(5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'hFFFF_FFFF);
      settle();
      check_eq("x0_data1", ex_data1_o, 32'd0);
      advance();
      set_fwd(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

      // PC/immediate operand select, store data still forwarded
      set_id(1'b1, 5'd4, 5'd3, 5'd9, 32'h1, 32'h99, 1'b0, 1'b0);
      id_src1_pc_i = 1'b1; id_src2_imm_i = 1'b1; id_pc_i = 32'h100; id_imm_i = 32'h20;
      id_mem_write_i = 1'b1;
      step();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      set_fwd(5'd0, 1'b0, 1'b0, 32'd0, 5'd3, 1'b1, 32'h33);
      settle();
      check_eq("sel_data1", ex_data1_o, 32'h100);
      check_eq("sel_data2", ex_data2_o, 32'h20);
`ifdef ID_EX_FORWARD_EN
      check_eq("sel_store", ex_store_data_o, 32'h33);
`else
      check_eq("sel_store", ex_store_data_o, 32'h99);
`endif
      advance();

      // reset in the middle of a load-use stall drops the held instruction
      set_fwd(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
      set_id(1'b1, 5'd2, 5'd0, 5'd7, 32'd0, 32'd0, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd7, 5'd1, 5'd8, 32'h1234, 32'h5, 1'b1, 1'b0);
      rst_i = 1'b1;
      settle();
      check_eq("rst_mid_stall", {31'd0, stall_o}, 32'd0);
      advance();
      rst_i = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      settle();
      check_eq("rst_discard", {31'd0, ex_valid_o}, 32'd0);
      advance();

      // random traffic; a stalled ID instruction is re-presented unchanged
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst_i   = ($urandom_range(0, 39) == 0);
         flush_i = ($urandom_range(0, 7) == 0);
         if (!held) begin
            id_valid_i     = ($urandom_range(0, 3) != 0);
            id_rs1_addr_i  = 5'($urandom_range(0, 3));
            id_rs2_addr_i  = 5'($urandom_range(0, 3));
            id_rd_addr_i   = 5'($urandom_range(0, 3));
            id_rs1_data_i  = $urandom;
            id_rs2_data_i  = $urandom;
            id_pc_i        = $urandom;
            id_imm_i       = $urandom;
            id_alu_op_i    = alu_op_t'(4'($urandom_range(0, 9)));
            id_src1_pc_i   = 1'($urandom_range(0, 1));
            id_src2_imm_i  = 1'($urandom_range(0, 1));
            id_reg_write_i = 1'($urandom_range(0, 1));
            id_mem_read_i  = ($urandom_range(0, 2) == 0);
            id_mem_write_i = 1'($urandom_range(0, 1));
         end
         set_fwd(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
